mem_store_ctrl: RTL and testbench

//  Store half of the memory controller: takes one store request (addr, 32-bit data, width) from the LSB
//  and drives it byte-serially onto the 8-bit RAM write port, little-endian, one byte per cycle.

---
 rtl/mem_store_ctrl_pkg.sv | 31 +++
 rtl/mem_store_ctrl.sv | 128 ++++++++++++
 tb/tb_mem_store_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_store_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mem_store_ctrl_pkg
//   Shared definitions for the store half of the memory controller:
//   controller states, store width codes, default I/O window base and a
//   helper that maps a width code to the index of the last byte to write.
// ----------------------------------------------------------------------------
package mem_store_ctrl_pkg;

   typedef enum logic {
      MS_IDLE  = 1'b0,
      MS_WRITE = 1'b1
   } ms_state_e;

   // Store width codes as presented by the LSB.
   localparam logic [1:0] ST_B = 2'b00;   // 1 byte
   localparam logic [1:0] ST_H = 2'b01;   // 2 bytes
   localparam logic [1:0] ST_W = 2'b10;   // 4 bytes (2'b11 also means word)

   // Lowest address of the memory-mapped I/O window.
   localparam logic [31:0] MS_IO_BASE = 32'h0003_0000;

   // Index of the final byte of a store: nbytes - 1.
   function automatic logic [1:0] last_index(input logic [1:0] width);
      case (width)
         ST_B:    return 2'd0;
         ST_H:    return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/mem_store_ctrl.sv
// ----------------------------------------------------------------------------
// mem_store_ctrl
//   Accepts one store request (address, 32-bit data, width) and writes it
//   byte-serially, little-endian, onto the 8-bit RAM write port, one byte per
//   cycle. Writes into the I/O window stall while io_buffer_full is high.
//   st_done pulses for one cycle once the last byte has been written.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   rdy              global ready; low freezes all state and blocks writes
//   st_valid/ready   request handshake (ready = IDLE && rdy)
//   st_addr          byte address of the lowest byte
//   st_data          store data, byte k = st_data[8k+7:8k]
//   st_width         00 byte, 01 half, 10/11 word
//   io_buffer_full   stalls writes whose address lies in the I/O window
//   mem_a/dout/wr    RAM byte write port
//   st_done          one-cycle pulse when the store is fully committed
// ----------------------------------------------------------------------------
module mem_store_ctrl
   import mem_store_ctrl_pkg::*;
#(
   parameter int unsigned          ADDR_W  = 32,
   parameter logic [ADDR_W-1:0]    IO_BASE = ADDR_W'(MS_IO_BASE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [31:0]       st_data,
   input  logic [1:0]        st_width,
   input  logic              io_buffer_full,
   output logic [ADDR_W-1:0] mem_a,
   output logic [7:0]        mem_dout,
   output logic              mem_wr,
   output logic              st_done
);

   ms_state_e         state_q, state_d;
   logic [1:0]        idx_q,   idx_d;    // byte currently on the bus
   logic [1:0]        last_q,  last_d;   // index of the final byte
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [31:0]       data_q,  data_d;
   logic              done_q,  done_d;   // completion waiting to be reported

   logic io_stall;
   logic byte_go;

   // The I/O decision uses the latched address, so the whole store is either
   // I/O or not, even if it wraps or straddles the window boundary.
   assign io_stall = (addr_q >= IO_BASE) && io_buffer_full;
   assign byte_go  = (state_q == MS_WRITE) && rdy && !io_stall;

   // NOTE: every signal gets its default before the case statement so that
   // no path leaves a variable unassigned, which would infer a latch.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      addr_d  = addr_q;
      data_d  = data_q;
      // A pending completion survives rdy-low cycles and clears once shown.
      done_d  = done_q && !rdy;

      case (state_q)
         MS_IDLE: begin
            if (st_valid && rdy) begin
               addr_d  = st_addr;
               data_d  = st_data;
               last_d  = last_index(st_width);
               idx_d   = 2'd0;
               state_d = MS_WRITE;
            end
         end
         MS_WRITE: begin
            if (byte_go) begin
               if (idx_q == last_q) begin
                  idx_d   = 2'd0;
                  done_d  = 1'b1;
                  state_d = MS_IDLE;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         default: state_d = MS_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from values sampled before the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= MS_IDLE;
         idx_q   <= 2'd0;
         last_q  <= 2'd0;
         addr_q  <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   assign st_ready = (state_q == MS_IDLE) && rdy;
   assign st_done  = done_q && rdy;
   assign mem_wr   = byte_go;
   // Address arithmetic wraps modulo 2^ADDR_W by construction.
   assign mem_a    = addr_q + ADDR_W'(idx_q);

   // 4:1 byte select on the current index.
   always_comb begin
      mem_dout = data_q[7:0];
      case (idx_q)
         2'd1:    mem_dout = data_q[15:8];
         2'd2:    mem_dout = data_q[23:16];
         2'd3:    mem_dout = data_q[31:24];
         default: mem_dout = data_q[7:0];
      endcase
   end

endmodule

// File: tb/tb_mem_store_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_store_ctrl
//   Self-checking bench for mem_store_ctrl. A per-cycle reference model keeps
//   a count of bytes already committed for the current store and derives the
//   expected bus activity from the store rules: a byte goes out in any cycle
//   with rdy high and no I/O stall, and completion is reported in the first
//   rdy-high cycle after the last byte.
// ----------------------------------------------------------------------------
module tb_mem_store_ctrl;

   localparam logic [31:0] IO_BASE = 32'h0003_0000;
   localparam logic [1:0]  W_B = 2'b00, W_H = 2'b01, W_W = 2'b10;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [1:0]  st_width;
   logic        io_buffer_full;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_wr;
   logic        st_done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_store_ctrl #(.ADDR_W(32), .IO_BASE(IO_BASE)) dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .st_valid       (st_valid),
      .st_ready       (st_ready),
      .st_addr        (st_addr),
      .st_data        (st_data),
      .st_width       (st_width),
      .io_buffer_full (io_buffer_full),
      .mem_a          (mem_a),
      .mem_dout       (mem_dout),
      .mem_wr         (mem_wr),
      .st_done        (st_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int width_bytes(input logic [1:0] w);
      if (w == W_B) return 1;
      if (w == W_H) return 2;
      return 4;
   endfunction

   // Runs one store and checks every cycle against the reference model.
   // chained: request fields are already driven and accepted at the next edge.
   // nx_*: request to present (held) right after this one is accepted.
   task automatic do_store(
      input  logic [31:0] a, input logic [31:0] d, input logic [1:0] w,
      input  int io_cyc, input int gap_s, input int gap_l,
      input  bit rnd, input bit chained,
      input  bit nx_v, input logic [31:0] nx_a, input logic [31:0] nx_d, input logic [1:0] nx_w,
      output int done_cyc, output logic [31:0] last_a, output logic [7:0] last_d);
      int          n;
      int          k;
      int          kb;
      bit          is_io;
      bit          exp_wr;
      bit          exp_done;
      logic [31:0] sh;
      n        = width_bytes(w);
      k        = 0;
      done_cyc = -1;
      last_a   = '0;
      last_d   = '0;
      is_io    = (a >= IO_BASE);
      if (!chained) begin
         @(posedge clk); #1;
         st_valid = 1'b1; st_addr = a; st_data = d; st_width = w;
         rdy = 1'b1; io_buffer_full = 1'b0;
         @(negedge clk);
      end
      check("st_ready at request", st_ready, 1);
      for (int cyc = 1; cyc <= 200; cyc++) begin
         @(posedge clk); #1;
         if (cyc == 1) begin
            st_valid = nx_v;
            if (nx_v) begin
               st_addr = nx_a; st_data = nx_d; st_width = nx_w;
            end
         end
         if (rnd) begin
            rdy            = ($urandom_range(3) != 0);
            io_buffer_full = ($urandom_range(2) == 0);
         end else begin
            rdy            = !(cyc >= gap_s && cyc < gap_s + gap_l);
            io_buffer_full = (cyc <= io_cyc);
         end
         @(negedge clk);
         kb     = k;
         exp_wr = (k < n) && rdy && !(is_io && io_buffer_full);
         check("mem_wr", mem_wr, exp_wr);
         if (exp_wr) begin
            sh = d >> (8 * k);
            check("mem_a", mem_a, a + 32'(k));
            check("mem_dout", mem_dout, sh[7:0]);
            last_a = a + 32'(k);
            last_d = sh[7:0];
            k++;
         end
         exp_done = (kb == n) && rdy;
         check("st_done", st_done, exp_done);
         check("st_ready", st_ready, exp_done);
         if (exp_done) begin
            done_cyc = cyc;
            break;
         end
      end
      if (done_cyc < 0) begin
         checks++;
         errors++;
         $display("FAIL store timeout: addr %h wrote %0d of %0d bytes, no st_done", a, k, n);
      end
   endtask

   // One quiet cycle after a store: pulse must be over, no stray write.
   task automatic idle_check();
      @(posedge clk); #1;
      st_valid = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
      @(negedge clk);
      check("st_done one cycle", st_done, 0);
      check("mem_wr idle", mem_wr, 0);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  width;
      int          exp_n;
      logic [31:0] exp_last_a;
      logic [7:0]  exp_last_d;
   } vec_t;

   initial begin
      vec_t        vecs[6];
      int          dc;
      logic [31:0] la;
      logic [7:0]  ld;
      logic [31:0] ra;

      vecs[0] = '{32'h0000_1000, 32'hDEAD_BEEF, W_W,   4, 32'h0000_1003, 8'hDE};
      vecs[1] = '{32'h0000_0020, 32'h1234_5678, W_B,   1, 32'h0000_0020, 8'h78};
      vecs[2] = '{32'h0000_0021, 32'h1234_5678, W_H,   2, 32'h0000_0022, 8'h56};
      vecs[3] = '{32'hFFFF_FFFE, 32'hCAFE_F00D, W_W,   4, 32'h0000_0001, 8'hCA};
      vecs[4] = '{32'h0000_0007, 32'hA1B2_C3D4, 2'b11, 4, 32'h0000_000A, 8'hA1};
      vecs[5] = '{32'h0003_0001, 32'h9988_7766, W_H,   2, 32'h0003_0002, 8'h77};

      rst = 1'b1; rdy = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
      st_width = W_B; io_buffer_full = 1'b0;

      // Reset state
      #2;
      check("reset mem_wr", mem_wr, 0);
      check("reset mem_a", mem_a, 0);
      check("reset mem_dout", mem_dout, 0);
      check("reset st_done", st_done, 0);
      check("reset st_ready rdy=1", st_ready, 1);
      rdy = 1'b0;
      #1 check("reset st_ready rdy=0", st_ready, 0);
      rdy = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // Table-driven stores without stalls
      for (int i = 0; i < 6; i++) begin
         do_store(vecs[i].addr, vecs[i].data, vecs[i].width, 0, 0, 0, 1'b0, 1'b0,
                  1'b0, '0, '0, W_B, dc, la, ld);
         check("table done cycle", dc, vecs[i].exp_n + 1);
         check("table last addr", la, vecs[i].exp_last_a);
         check("table last byte", ld, 32'(vecs[i].exp_last_d));
         idle_check();
      end

      // I/O stall for three cycles, then byte and done
      do_store(32'h0003_0000, 32'h0000_0041, W_B, 3, 0, 0, 1'b0, 1'b0,
               1'b0, '0, '0, W_B, dc, la, ld);
      check("io stall done cycle", dc, 5);
      idle_check();

      // Just below the I/O window: io_buffer_full is ignored
      do_store(32'h0002_FFFF, 32'h0000_0041, W_B, 3, 0, 0, 1'b0, 1'b0,
               1'b0, '0, '0, W_B, dc, la, ld);
      check("non-io no stall", dc, 2);
      idle_check();

      // rdy low for two cycles after byte 1
      do_store(32'h0000_1000, 32'h0102_0304, W_W, 0, 2, 2, 1'b0, 1'b0,
               1'b0, '0, '0, W_B, dc, la, ld);
      check("rdy gap done cycle", dc, 7);
      idle_check();

      // rdy low right after the last byte: completion delayed
      do_store(32'h0000_0100, 32'h5566_7788, W_H, 0, 3, 2, 1'b0, 1'b0,
               1'b0, '0, '0, W_B, dc, la, ld);
      check("delayed done cycle", dc, 5);
      idle_check();

      // Reset during the third byte of a word store
      @(posedge clk); #1;
      st_valid = 1'b1; st_addr = 32'h0000_2000; st_data = 32'h1122_3344; st_width = W_W;
      @(posedge clk); #1;
      st_valid = 1'b0;
      @(negedge clk);
      check("pre-reset byte0", mem_dout, 8'h44);
      check("pre-reset wr0", mem_wr, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("pre-reset byte1", mem_dout, 8'h33);
      check("pre-reset addr1", mem_a, 32'h0000_2001);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("abort mem_wr", mem_wr, 0);
      check("abort st_done", st_done, 0);
      @(posedge clk); #1;
      check("abort no done", st_done, 0);
      @(negedge clk);
      rst = 1'b0;
      do_store(32'h0000_2100, 32'h5566_7788, W_W, 0, 0, 0, 1'b0, 1'b0,
               1'b0, '0, '0, W_B, dc, la, ld);
      check("post-reset done cycle", dc, 5);
      idle_check();

      // Back-to-back half stores, second request held valid throughout
      do_store(32'h0000_0400, 32'hAABB_CCDD, W_H, 0, 0, 0, 1'b0, 1'b0,
               1'b1, 32'h0000_0500, 32'h1122_3344, W_H, dc, la, ld);
      check("b2b first done", dc, 3);
      do_store(32'h0000_0500, 32'h1122_3344, W_H, 0, 0, 0, 1'b0, 1'b1,
               1'b0, '0, '0, W_B, dc, la, ld);
      check("b2b second done", dc, 3);
      idle_check();

      // Randomized stores with random rdy and io_buffer_full
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(2))
            0:       ra = $urandom;
            1:       ra = IO_BASE + 32'($urandom_range(15));
            default: ra = 32'hFFFF_FFFC + 32'($urandom_range(3));
         endcase
         do_store(ra, $urandom, 2'($urandom_range(3)), 0, 0, 0, 1'b1, 1'b0,
                  1'b0, '0, '0, W_B, dc, la, ld);
      end
      idle_check();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
